// File: rtl/wb_reg_file.sv
// Write-back mux plus 32-entry architectural register file with write-first read bypass.
// Register 0 has no storage; a retired-write counter tracks committed writes.
module wb_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_IDX   = 29,
    parameter int SP_RESET = 128,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] MemData_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic [CNT_W-1:0]  wb_count_o
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [DATA_W-1:0] regs_d [1:NREG-1];
    logic [CNT_W-1:0]  wb_count_q;
    logic [CNT_W-1:0]  wb_count_d;
    logic              we_eff;

    assign WBdata_o = MemtoReg_i ? MemData_i : ALU_result_i;
    assign we_eff   = rst_i & RegWrite_i & (RDaddr_i != '0);

    // Entry 0 is absent, so every array access goes through an explicit index decode.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (rst_i && addr != '0) begin
            if (we_eff && RDaddr_i == addr) begin
                val = WBdata_o;
            end else begin
                for (int i = 1; i < NREG; i++) begin
                    if (addr == ADDR_W'(i)) val = regs_q[i];
                end
            end
        end
        return val;
    endfunction

    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = (we_eff && RDaddr_i == ADDR_W'(i)) ? WBdata_o : regs_q[i];
        end
        wb_count_d = we_eff ? wb_count_q + CNT_W'(1) : wb_count_q;
    end

    always_comb begin
        RSdata_o = read_port(RSaddr_i);
        RTdata_o = read_port(RTaddr_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
            wb_count_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count_o = wb_count_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed and randomized checks of wb_reg_file; counter narrowed to 4 bits so wrap is reachable.
module tb_wb_reg_file;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic [31:0] MemData_i;
    logic [31:0] ALU_result_i;
    logic [4:0]  RDaddr_i;
    logic [4:0]  RSaddr_i;
    logic [4:0]  RTaddr_i;
    logic [31:0] RSdata_o;
    logic [31:0] RTdata_o;
    logic [31:0] WBdata_o;
    logic [3:0]  wb_count_o;

    int passed = 0;
    int total  = 0;

    logic [31:0] m [32];
    int          mcnt;

    wb_reg_file #(
        .DATA_W(32), .ADDR_W(5), .SP_IDX(29), .SP_RESET(128), .CNT_W(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .MemData_i(MemData_i), .ALU_result_i(ALU_result_i), .RDaddr_i(RDaddr_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(RSdata_o), .RTdata_o(RTdata_o),
        .WBdata_o(WBdata_o), .wb_count_o(wb_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
        RegWrite_i   = we;
        MemtoReg_i   = m2r;
        MemData_i    = mem;
        ALU_result_i = alu;
        RDaddr_i     = rd;
        RSaddr_i     = rs;
        RTaddr_i     = rt;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [31:0] wb);
        if (a == 5'd0) return 32'h0;
        if (RegWrite_i && RDaddr_i != 5'd0 && RDaddr_i == a) return wb;
        return m[a];
    endfunction

    initial begin
        logic [31:0] wbexp;

        rst_i = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_00A5, 32'h0000_0001, 5'd3, 5'd29, 5'd5);
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_rs_zero", RSdata_o, 32'h0);
        check("rst_rt_zero", RTdata_o, 32'h0);
        check("rst_count", 32'(wb_count_o), 32'h0);
        check("rst_wbdata_follows", WBdata_o, 32'h0000_00A5);

        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd29, 5'd5);
        rst_i = 1'b1;
        #1;
        check("release_sp", RSdata_o, 32'd128);
        check("release_r5", RTdata_o, 32'h0);
        check("release_r3_not_written", 32'(wb_count_o), 32'h0);

        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd8, 5'd8, 5'd0);
        #1;
        check("wr8_bypass_rs", RSdata_o, 32'h1234_5678);
        check("wr8_rt_r0", RTdata_o, 32'h0);
        check("wr8_wbdata", WBdata_o, 32'h1234_5678);

        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd3);
        #1;
        check("rd8_stored", RSdata_o, 32'h1234_5678);
        check("rd3_untouched", RTdata_o, 32'h0);
        check("count_after_1", 32'(wb_count_o), 32'd1);

        @(negedge clk_i);
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd9, 5'd9, 5'd9);
        #1;
        check("mux_bypass_rs", RSdata_o, 32'hDEAD_BEEF);
        check("mux_bypass_rt", RTdata_o, 32'hDEAD_BEEF);
        check("mux_wbdata", WBdata_o, 32'hDEAD_BEEF);

        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd8);
        #1;
        check("rd9_stored", RSdata_o, 32'hDEAD_BEEF);
        check("rd8_kept", RTdata_o, 32'h1234_5678);
        check("count_after_2", 32'(wb_count_o), 32'd2);

        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        #1;
        check("r0_write_rs", RSdata_o, 32'h0);
        check("r0_write_wbdata", WBdata_o, 32'hFFFF_FFFF);

        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 32'h0000_0055, 5'd8, 5'd8, 5'd0);
        #1;
        check("no_we_no_bypass", RSdata_o, 32'h1234_5678);
        check("r0_still_zero", RTdata_o, 32'h0);
        check("r0_write_not_counted", 32'(wb_count_o), 32'd2);

        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0111, 5'd10, 5'd0, 5'd0);
        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0222, 5'd10, 5'd0, 5'd0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
        #1;
        check("b2b_last_wins", RSdata_o, 32'h0000_0222);
        check("b2b_count", 32'(wb_count_o), 32'd4);

        // 4 writes so far; 13 more makes 17, which wraps a 4-bit counter to 1.
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk_i);
            drive(1'b1, 1'b0, 32'h0, 32'(i * 3), 5'(i), 5'd0, 5'd0);
        end
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd13, 5'd1);
        #1;
        check("wrap_count", 32'(wb_count_o), 32'd1);
        check("wrap_r13", RSdata_o, 32'd39);
        check("wrap_r1", RTdata_o, 32'd3);

        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0777, 5'd11, 5'd8, 5'd11);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_count", 32'(wb_count_o), 32'h0);
        check("async_rst_rs", RSdata_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd11, 5'd8);
        #1;
        check("async_rst_pending_lost", RSdata_o, 32'h0);
        check("async_rst_r8_cleared", RTdata_o, 32'h0);
        RSaddr_i = 5'd29;
        RTaddr_i = 5'd13;
        #1;
        check("async_rst_sp", RSdata_o, 32'd128);
        check("async_rst_r13_cleared", RTdata_o, 32'h0);
        check("async_rst_count_after", 32'(wb_count_o), 32'h0);

        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        m[29] = 32'd128;
        mcnt  = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk_i);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) RSaddr_i = RDaddr_i;
            if ($urandom_range(0, 3) == 0) RTaddr_i = RDaddr_i;
            wbexp = MemtoReg_i ? MemData_i : ALU_result_i;
            #1;
            check("rand_wbdata", WBdata_o, wbexp);
            check("rand_rs", RSdata_o, model_read(RSaddr_i, wbexp));
            check("rand_rt", RTdata_o, model_read(RTaddr_i, wbexp));
            check("rand_count", 32'(wb_count_o), 32'(mcnt % 16));
            if (RegWrite_i && RDaddr_i != 5'd0) begin
                m[RDaddr_i] = wbexp;
                mcnt++;
            end
        end
        @(negedge clk_i);
        #1;
        check("rand_final_count", 32'(wb_count_o), 32'(mcnt % 16));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
